// File: rtl/rf_scrub_ctrl_pkg.sv
// rtl/rf_scrub_ctrl_pkg.sv - shared types and helpers for the register-file scrubber
// Holds the scrub FSM encoding and the register-file address type.
package rf_scrub_ctrl_pkg;

  typedef logic [4:0] rf_add;

  typedef enum logic [1:0] {
    SCRUB_IDLE = 2'd0,
    SCRUB_WAIT = 2'd1,
    SCRUB_REQ  = 2'd2,
    SCRUB_HOLD = 2'd3
  } scrub_fsm;

  localparam rf_add SCRUB_ADD_FIRST = 5'd1;
  localparam rf_add SCRUB_ADD_LAST  = 5'd31;

  // x0 is hard-wired zero, so the walk covers x1..x31 only
  function automatic rf_add scrub_next_add(input rf_add a);
    return (a == SCRUB_ADD_LAST) ? SCRUB_ADD_FIRST : rf_add'(a + 5'd1);
  endfunction

endpackage

// File: rtl/rf_scrub_ctrl_if.sv
// rtl/rf_scrub_ctrl_if.sv - control/status bundle between decode, ACM and the scrubber
// master drives the scrub controls and sees the grant; slave is the scrubber itself.
interface rf_scrub_ctrl_if #(
  parameter int IW = 16,
  parameter int CW = 8
);

  logic          s_enable_i;
  logic [IW-1:0] s_interval_i;
  logic          s_port_free_i;
  logic          s_acm_busy_i;
  logic          s_acm_repair_i;
  logic          s_cnt_clr_i;
  logic          s_scrub_req_o;
  logic [4:0]    s_scrub_add_o;
  logic          s_busy_o;
  logic [CW-1:0] s_corr_cnt_o;

  modport master (
    output s_enable_i, s_interval_i, s_port_free_i, s_acm_busy_i, s_acm_repair_i, s_cnt_clr_i,
    input  s_scrub_req_o, s_scrub_add_o, s_busy_o, s_corr_cnt_o
  );

  modport slave (
    input  s_enable_i, s_interval_i, s_port_free_i, s_acm_busy_i, s_acm_repair_i, s_cnt_clr_i,
    output s_scrub_req_o, s_scrub_add_o, s_busy_o, s_corr_cnt_o
  );

endinterface

// File: rtl/rf_scrub_ctrl_sat_counter.sv
// rtl/rf_scrub_ctrl_sat_counter.sv - saturating event counter, clear wins over increment
// Holds at all-ones instead of wrapping so long-running statistics never alias to small values.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {W{1'b1}})) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/rf_scrub_ctrl_seu_ff_rst.sv
// rtl/rf_scrub_ctrl_seu_ff_rst.sv - fault-injectable register with async active-low reset
// Kept as a distinct cell so upset-injection tooling can target every instance.
module seu_ff_rst #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      q_o <= RST_VAL;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/rf_scrub_ctrl.sv
// rtl/rf_scrub_ctrl.sv - background ECC scrubber borrowing idle read port 2 (x1..x31)
// Optional statistics counter built only when ACM_SCRUB_STATS_EN is defined.
module rf_scrub_ctrl
  import rf_scrub_ctrl_pkg::*;
#(
  parameter int IW = 16,
  parameter int CW = 8
) (
  input  logic            s_clk_i,
  input  logic            s_resetn_i,
  rf_scrub_ctrl_if.slave  bus
);

  logic [1:0]    state_q;
  scrub_fsm      state;
  scrub_fsm      state_n;
  rf_add         add_q;
  rf_add         add_n;
  logic [IW-1:0] cnt_q;
  logic [IW-1:0] cnt_n;
  logic [IW-1:0] reload;
  logic          run;
  logic          grant;
  logic          busy;

  assign state  = scrub_fsm'(state_q);
  assign run    = bus.s_enable_i && (bus.s_interval_i != '0);
  // interval is sampled only here, so a new value lands at the next reload
  assign reload = bus.s_interval_i - IW'(1);

  seu_ff_rst #(.W(2), .RST_VAL(2'(SCRUB_IDLE))) u_state_ff (
    .clk_i  (s_clk_i),
    .rstn_i (s_resetn_i),
    .d_i    (state_n),
    .q_o    (state_q)
  );

  seu_ff_rst #(.W(5), .RST_VAL(SCRUB_ADD_FIRST)) u_add_ff (
    .clk_i  (s_clk_i),
    .rstn_i (s_resetn_i),
    .d_i    (add_n),
    .q_o    (add_q)
  );

  seu_ff_rst #(.W(IW), .RST_VAL('0)) u_cnt_ff (
    .clk_i  (s_clk_i),
    .rstn_i (s_resetn_i),
    .d_i    (cnt_n),
    .q_o    (cnt_q)
  );

  always_comb begin
    state_n = state;
    add_n   = add_q;
    cnt_n   = cnt_q;
    if (!run) begin
      state_n = SCRUB_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        SCRUB_IDLE: begin
          state_n = SCRUB_WAIT;
          cnt_n   = reload;
        end
        SCRUB_WAIT: begin
          if (cnt_q == '0) begin
            state_n = SCRUB_REQ;
          end else begin
            cnt_n = cnt_q - IW'(1);
          end
        end
        SCRUB_REQ: begin
          // no grant means wait indefinitely: decode always has priority on the port
          if (grant) begin
            add_n   = scrub_next_add(add_q);
            cnt_n   = reload;
            state_n = bus.s_acm_repair_i ? SCRUB_HOLD : SCRUB_WAIT;
          end
        end
        SCRUB_HOLD: begin
          if (!bus.s_acm_busy_i) begin
            state_n = SCRUB_WAIT;
            cnt_n   = reload;
          end
        end
        default: state_n = SCRUB_IDLE;
      endcase
    end
  end

  always_comb begin
    grant = 1'b0;
    busy  = (state != SCRUB_IDLE);
    if (state == SCRUB_REQ) begin
      grant = run && bus.s_port_free_i && !bus.s_acm_busy_i;
    end
  end

  assign bus.s_scrub_req_o = grant;
  assign bus.s_scrub_add_o = grant ? add_q : 5'd0;
  assign bus.s_busy_o      = busy;

`ifdef ACM_SCRUB_STATS_EN
  sat_counter #(.W(CW)) u_stats (
    .clk_i  (s_clk_i),
    .rstn_i (s_resetn_i),
    .clr_i  (bus.s_cnt_clr_i),
    .inc_i  (grant && bus.s_acm_repair_i),
    .cnt_o  (bus.s_corr_cnt_o)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr   = bus.s_cnt_clr_i;
  assign bus.s_corr_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rf_scrub_ctrl.sv
// tb/tb_rf_scrub_ctrl.sv - self-checking bench for rf_scrub_ctrl against a cycle reference model
// Statistics expectations follow ACM_SCRUB_STATS_EN when defined.
module tb_rf_scrub_ctrl;

  localparam int IW = 16;
  localparam int CW = 2;
`ifdef ACM_SCRUB_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_scrub_ctrl_if #(.IW(IW), .CW(CW)) bus ();

  rf_scrub_ctrl #(.IW(IW), .CW(CW)) dut (
    .s_clk_i    (clk),
    .s_resetn_i (rst_n),
    .bus        (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // reference: "is scrubbing running", "in a repair hold", cycles left before asking, next address
  bit              m_active;
  bit              m_hold;
  int              m_wait;
  int              m_addr;
  int              m_cnt;
  logic            exp_req;
  logic [4:0]      exp_add;
  logic            exp_busy;
  logic [CW-1:0]   exp_cnt;

  function void model_reset();
    m_active = 1'b0;
    m_hold   = 1'b0;
    m_wait   = 0;
    m_addr   = 1;
    m_cnt    = 0;
  endfunction

  function bit model_run();
    return bus.s_enable_i && (bus.s_interval_i != 0);
  endfunction

  function bit model_window();
    return m_active && !m_hold && (m_wait == 0);
  endfunction

  function void model_eval();
    exp_req  = model_run() && model_window() && bus.s_port_free_i && !bus.s_acm_busy_i;
    exp_add  = exp_req ? 5'(m_addr) : 5'd0;
    exp_busy = m_active;
    exp_cnt  = CW'(m_cnt);
  endfunction

  function void model_update();
    if (STATS_ON) begin
      if (bus.s_cnt_clr_i) m_cnt = 0;
      else if (exp_req && bus.s_acm_repair_i && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
    if (!model_run()) begin
      m_active = 1'b0;
      m_hold   = 1'b0;
      m_wait   = 0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_wait   = int'(bus.s_interval_i);
    end else if (m_hold) begin
      if (!bus.s_acm_busy_i) begin
        m_hold = 1'b0;
        m_wait = int'(bus.s_interval_i);
      end
    end else if (m_wait > 0) begin
      m_wait = m_wait - 1;
    end else if (exp_req) begin
      m_addr = (m_addr % 31) + 1;
      m_wait = int'(bus.s_interval_i);
      m_hold = bus.s_acm_repair_i;
    end
  endfunction

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input bit en, input int iv, input bit fr, input bit bz, input bit rp);
    bus.s_enable_i     = en;
    bus.s_interval_i   = IW'(iv);
    bus.s_port_free_i  = fr;
    bus.s_acm_busy_i   = bz;
    bus.s_acm_repair_i = rp;
    bus.s_cnt_clr_i    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_inputs(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_inputs(1, 4, 1, 0, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.s_scrub_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", bus.s_scrub_req_o); end
    checks++; if (bus.s_scrub_add_o !== 5'd0) begin errors++; $display("FAIL reset_add: got %0d want 0", bus.s_scrub_add_o); end
    checks++; if (bus.s_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", bus.s_busy_o); end
    checks++; if (bus.s_corr_cnt_o !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bus.s_corr_cnt_o); end
    do_reset();
  endtask

  task automatic test_periodic();
    int last = -1;
    int ngr = 0;
    int want_a = 1;
    do_reset();
    set_inputs(1, 4, 1, 0, 0);
    for (int cyc = 0; cyc < 165; cyc++) begin
      sample();
      checks++;
      if (bus.s_scrub_req_o !== exp_req || bus.s_scrub_add_o !== exp_add || bus.s_busy_o !== exp_busy) begin
        errors++;
        $display("FAIL periodic c%0d: req=%0b add=%0d busy=%0b want req=%0b add=%0d busy=%0b",
                 cyc, bus.s_scrub_req_o, bus.s_scrub_add_o, bus.s_busy_o, exp_req, exp_add, exp_busy);
      end
      if (bus.s_scrub_req_o === 1'b1) begin
        checks++;
        if (bus.s_scrub_add_o !== 5'(want_a) || (last >= 0 && cyc - last != 5) || (last < 0 && cyc != 5)) begin
          errors++;
          $display("FAIL periodic_seq c%0d: add=%0d gap=%0d want add=%0d gap=5", cyc, bus.s_scrub_add_o, cyc - last, want_a);
        end
        want_a = (want_a == 31) ? 1 : want_a + 1;
        last = cyc;
        ngr++;
      end
      advance();
    end
    checks++; if (ngr != 32) begin errors++; $display("FAIL periodic_count: got %0d grants want 32", ngr); end
  endtask

  task automatic test_port_blocked();
    do_reset();
    set_inputs(1, 2, 0, 0, 0);
    repeat (3) advance();
    for (int i = 0; i < 10; i++) begin
      sample();
      checks++;
      if (bus.s_scrub_req_o !== 1'b0 || bus.s_busy_o !== 1'b1 || exp_req !== 1'b0) begin
        errors++;
        $display("FAIL blocked c%0d: req=%0b busy=%0b want req=0 busy=1", i, bus.s_scrub_req_o, bus.s_busy_o);
      end
      advance();
    end
    bus.s_port_free_i = 1'b1;
    sample();
    checks++;
    if (bus.s_scrub_req_o !== 1'b1 || bus.s_scrub_add_o !== 5'd1) begin
      errors++;
      $display("FAIL blocked_grant: req=%0b add=%0d want req=1 add=1", bus.s_scrub_req_o, bus.s_scrub_add_o);
    end
    advance();
    sample();
    checks++;
    if (bus.s_scrub_req_o !== 1'b0) begin errors++; $display("FAIL blocked_single: req=%0b want 0", bus.s_scrub_req_o); end
    advance();
  endtask

  task automatic test_repair_hold();
    bit seen = 1'b0;
    int gap = 0;
    do_reset();
    set_inputs(1, 3, 1, 0, 1);
    for (int i = 0; i < 20 && !seen; i++) begin
      sample();
      seen = (bus.s_scrub_req_o === 1'b1);
      advance();
    end
    checks++; if (!seen) begin errors++; $display("FAIL hold_grant: req=0 want 1 within 20 cycles"); end
    bus.s_acm_repair_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.s_acm_busy_i = 1'b1;
      sample();
      checks++;
      if (bus.s_scrub_req_o !== 1'b0 || bus.s_busy_o !== 1'b1) begin
        errors++;
        $display("FAIL hold_busy c%0d: req=%0b busy=%0b want req=0 busy=1", i, bus.s_scrub_req_o, bus.s_busy_o);
      end
      advance();
    end
    bus.s_acm_busy_i = 1'b0;
    advance();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      sample();
      seen = (bus.s_scrub_req_o === 1'b1);
      if (!seen) gap++;
      advance();
    end
    checks++; if (gap != 3) begin errors++; $display("FAIL hold_relatency: got %0d want 3", gap); end
    checks++;
    if (bus.s_corr_cnt_o !== CW'(STATS_ON ? 1 : 0)) begin
      errors++;
      $display("FAIL hold_cnt: got %0d want %0d", bus.s_corr_cnt_o, STATS_ON ? 1 : 0);
    end
  endtask

  task automatic test_disable_resume();
    bit found = 1'b0;
    bit seen = 1'b0;
    do_reset();
    set_inputs(1, 1, 1, 0, 0);
    for (int i = 0; i < 200 && !found; i++) begin
      bus.s_port_free_i = !(model_window() && m_addr == 17);
      sample();
      found = !bus.s_port_free_i;
      checks++;
      if (bus.s_scrub_req_o !== exp_req || bus.s_scrub_add_o !== exp_add) begin
        errors++;
        $display("FAIL resume_walk: req=%0b add=%0d want req=%0b add=%0d", bus.s_scrub_req_o, bus.s_scrub_add_o, exp_req, exp_add);
      end
      advance();
    end
    bus.s_enable_i = 1'b0;
    sample();
    checks++; if (bus.s_scrub_req_o !== 1'b0) begin errors++; $display("FAIL resume_off_req: req=%0b want 0", bus.s_scrub_req_o); end
    advance();
    sample();
    checks++; if (bus.s_busy_o !== 1'b0) begin errors++; $display("FAIL resume_idle: busy=%0b want 0", bus.s_busy_o); end
    advance();
    bus.s_enable_i = 1'b1;
    bus.s_port_free_i = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      sample();
      if (bus.s_scrub_req_o === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (bus.s_scrub_add_o !== 5'd17) begin errors++; $display("FAIL resume_add: got %0d want 17", bus.s_scrub_add_o); end
      end
      advance();
    end
    checks++; if (!seen) begin errors++; $display("FAIL resume_req: req=0 want 1 within 20 cycles"); end
  endtask

  task automatic test_stats_sat();
    int ngr = 0;
    bit saw = 1'b0;
    do_reset();
    set_inputs(1, 1, 1, 0, 1);
    for (int i = 0; i < 60 && ngr < 5; i++) begin
      sample();
      checks++;
      if (bus.s_scrub_req_o !== exp_req || bus.s_corr_cnt_o !== exp_cnt) begin
        errors++;
        $display("FAIL sat_walk: req=%0b cnt=%0d want req=%0b cnt=%0d", bus.s_scrub_req_o, bus.s_corr_cnt_o, exp_req, exp_cnt);
      end
      if (bus.s_scrub_req_o === 1'b1) ngr++;
      advance();
    end
    sample();
    checks++;
    if (bus.s_corr_cnt_o !== CW'(STATS_ON ? 3 : 0)) begin
      errors++;
      $display("FAIL sat_value: got %0d want %0d", bus.s_corr_cnt_o, STATS_ON ? 3 : 0);
    end
    advance();
    for (int i = 0; i < 20 && !saw; i++) begin
      bus.s_cnt_clr_i = model_window() && model_run();
      sample();
      saw = (bus.s_scrub_req_o === 1'b1);
      advance();
    end
    bus.s_cnt_clr_i = 1'b0;
    bus.s_acm_repair_i = 1'b0;
    sample();
    checks++;
    if (!saw || bus.s_corr_cnt_o !== '0) begin
      errors++;
      $display("FAIL sat_clear: cnt=%0d grant_seen=%0b want cnt=0 grant_seen=1", bus.s_corr_cnt_o, saw);
    end
    advance();
  endtask

  task automatic test_random();
    do_reset();
    set_inputs(1, 3, 1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 64 == 0) bus.s_enable_i = ~bus.s_enable_i;
      if ($urandom % 128 == 0) bus.s_interval_i = IW'($urandom_range(0, 5));
      bus.s_port_free_i  = ($urandom % 4) != 0;
      bus.s_acm_busy_i   = ($urandom % 4) == 0;
      bus.s_acm_repair_i = ($urandom % 3) == 0;
      bus.s_cnt_clr_i    = ($urandom % 50) == 0;
      sample();
      checks++;
      if (bus.s_scrub_req_o !== exp_req || bus.s_scrub_add_o !== exp_add ||
          bus.s_busy_o !== exp_busy || bus.s_corr_cnt_o !== exp_cnt) begin
        errors++;
        $display("FAIL random c%0d: req=%0b add=%0d busy=%0b cnt=%0d want req=%0b add=%0d busy=%0b cnt=%0d",
                 i, bus.s_scrub_req_o, bus.s_scrub_add_o, bus.s_busy_o, bus.s_corr_cnt_o,
                 exp_req, exp_add, exp_busy, exp_cnt);
      end
      advance();
    end
  endtask

  task automatic test_reset_in_hold();
    bit seen = 1'b0;
    do_reset();
    set_inputs(1, 2, 1, 0, 1);
    for (int i = 0; i < 20 && !seen; i++) begin
      sample();
      seen = (bus.s_scrub_req_o === 1'b1);
      advance();
    end
    bus.s_acm_busy_i = 1'b1;
    sample();
    checks++; if (bus.s_busy_o !== 1'b1 || !m_hold) begin errors++; $display("FAIL rsthold_pre: busy=%0b hold=%0b want 1 1", bus.s_busy_o, m_hold); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.s_scrub_req_o !== 1'b0 || bus.s_scrub_add_o !== 5'd0 || bus.s_busy_o !== 1'b0 || bus.s_corr_cnt_o !== '0) begin
      errors++;
      $display("FAIL rsthold_async: req=%0b add=%0d busy=%0b cnt=%0d want all 0",
               bus.s_scrub_req_o, bus.s_scrub_add_o, bus.s_busy_o, bus.s_corr_cnt_o);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.s_acm_busy_i = 1'b0;
    bus.s_acm_repair_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      sample();
      if (bus.s_scrub_req_o === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (bus.s_scrub_add_o !== 5'd1) begin errors++; $display("FAIL rsthold_add: got %0d want 1", bus.s_scrub_add_o); end
      end
      advance();
    end
    checks++; if (!seen) begin errors++; $display("FAIL rsthold_req: req=0 want 1 within 20 cycles"); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_periodic();
    test_port_blocked();
    test_repair_hold();
    test_disable_resume();
    test_stats_sat();
    test_random();
    test_reset_in_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
